// File: rtl/sqw_pkg.sv
// Shared types and defaults for the square-wave generator/meter pair.
// The unit type is also used by the generator's m/n ports, so keep it 4 bits wide.
package sqw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STALL = 2'd3
    } sqw_meter_state_t;

    localparam int SQW_TICK_DEFAULT = 10;
    localparam int SQW_MAX_UNITS    = 15;

    typedef logic [3:0] sqw_units_t;

endpackage

// File: rtl/sqw_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus one delay stage for
// single-cycle rise/fall strobes. Usable by any block with an async input.
module sqw_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic [2:0] r_primed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_primed <= 3'b000;
        end else begin
            r_s1     <= i_async;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_primed <= {r_primed[1:0], 1'b1};
        end
    end

    // Edges are suppressed until s3 holds a real sample, so a level already
    // present at reset release is not mistaken for a transition.
    assign o_rise = r_primed[2] & r_s2 & ~r_s3;
    assign o_fall = r_primed[2] & ~r_s2 & r_s3;

endmodule

// File: rtl/square_wave_meter.sv
// Recovers the (m, n) on/off interval pair of an incoming square wave in units
// of TICK clock cycles; flags malformed periods and stalled levels.
module square_wave_meter
    import sqw_pkg::*;
#(
    parameter int TICK      = SQW_TICK_DEFAULT,
    parameter int MAX_UNITS = SQW_MAX_UNITS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wave_in,
    output logic [3:0] m_out,
    output logic [3:0] n_out,
    output logic       valid,
    output logic       err,
    output logic       stuck,
    output logic [1:0] o_dbg_state
);

    localparam int SUB_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICK - 1);
    localparam logic [SUB_W-1:0] SUB_ONE  = (TICK > 1) ? SUB_W'(1) : '0;
    localparam logic [4:0]       UNIT_ONE = (TICK > 1) ? 5'd0 : 5'd1;
    localparam logic [4:0]       UNIT_MAX = 5'(MAX_UNITS);

    logic w_rise;
    logic w_fall;

    sqw_sync_edge u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (wave_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    sqw_meter_state_t r_state, w_state_nxt;
    logic [SUB_W-1:0] r_sub, w_sub_nxt, w_sub_inc;
    logic [4:0]       r_unit, w_unit_nxt, w_unit_inc;
    sqw_units_t       r_h_units, w_h_units_nxt;
    logic             r_h_ok, w_h_ok_nxt;
    sqw_units_t       r_m, w_m_nxt;
    sqw_units_t       r_n, w_n_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_err, w_err_nxt;
    logic             w_count_ok;
    logic             w_at_limit;

    // The counters hold the number of cycles already spent at the current
    // level, so at an edge they equal the full interval length.
    assign w_count_ok = (r_sub == '0) && (r_unit != 5'd0) && (r_unit <= UNIT_MAX);
    assign w_at_limit = (r_sub == '0) && (r_unit == UNIT_MAX);

    always_comb begin
        w_sub_inc  = r_sub + 1'b1;
        w_unit_inc = r_unit;
        if (r_sub == SUB_LAST) begin
            w_sub_inc  = '0;
            w_unit_inc = r_unit + 5'd1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sub_nxt     = r_sub;
        w_unit_nxt    = r_unit;
        w_h_units_nxt = r_h_units;
        w_h_ok_nxt    = r_h_ok;
        w_m_nxt       = r_m;
        w_n_nxt       = r_n;
        w_valid_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            IDLE, STALL: begin
                if (w_rise) begin
                    w_state_nxt = HIGH;
                    w_sub_nxt   = SUB_ONE;
                    w_unit_nxt  = UNIT_ONE;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_state_nxt   = LOW;
                    w_h_units_nxt = r_unit[3:0];
                    w_h_ok_nxt    = w_count_ok;
                    w_sub_nxt     = SUB_ONE;
                    w_unit_nxt    = UNIT_ONE;
                end else if (w_at_limit) begin
                    w_state_nxt = STALL;
                    w_err_nxt   = 1'b1;
                    w_sub_nxt   = '0;
                    w_unit_nxt  = 5'd0;
                end else begin
                    w_sub_nxt  = w_sub_inc;
                    w_unit_nxt = w_unit_inc;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_state_nxt = HIGH;
                    w_sub_nxt   = SUB_ONE;
                    w_unit_nxt  = UNIT_ONE;
                    if (r_h_ok && w_count_ok) begin
                        w_m_nxt     = r_h_units;
                        w_n_nxt     = r_unit[3:0];
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_at_limit) begin
                    w_state_nxt = STALL;
                    w_err_nxt   = 1'b1;
                    w_sub_nxt   = '0;
                    w_unit_nxt  = 5'd0;
                end else begin
                    w_sub_nxt  = w_sub_inc;
                    w_unit_nxt = w_unit_inc;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sub     <= '0;
            r_unit    <= 5'd0;
            r_h_units <= '0;
            r_h_ok    <= 1'b0;
            r_m       <= '0;
            r_n       <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sub     <= w_sub_nxt;
            r_unit    <= w_unit_nxt;
            r_h_units <= w_h_units_nxt;
            r_h_ok    <= w_h_ok_nxt;
            r_m       <= w_m_nxt;
            r_n       <= w_n_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign m_out       = r_m;
    assign n_out       = r_n;
    assign valid       = r_valid;
    assign err         = r_err;
    assign stuck       = (r_state == STALL);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_square_wave_meter.sv
// Directed bench for square_wave_meter: drives hand-timed waveforms and
// checks pulse counts, spacing, reported pairs, stall behaviour and reset.
module tb_square_wave_meter;
    import sqw_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wave_in = 1'b0;
    logic [3:0] m_out;
    logic [3:0] n_out;
    logic       valid;
    logic       err;
    logic       stuck;
    logic [1:0] o_dbg_state;

    int checks = 0;
    int errors = 0;

    square_wave_meter #(.TICK(10), .MAX_UNITS(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .wave_in     (wave_in),
        .m_out       (m_out),
        .n_out       (n_out),
        .valid       (valid),
        .err         (err),
        .stuck       (stuck),
        .o_dbg_state (o_dbg_state)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts valid/err pulses, records valid spacing and
    // tallies protocol violations (valid with err, m/n moving without valid).
    int         cyc = 0;
    logic       rst_q = 1'b1;
    int         valid_cnt = 0;
    int         err_cnt = 0;
    int         last_valid_cyc = 0;
    int         spacing = 0;
    int         viol = 0;
    logic [3:0] prev_m = '0;
    logic [3:0] prev_n = '0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    always @(negedge clk) begin
        if (!rst_q) begin
            if (valid === 1'b1) begin
                valid_cnt      <= valid_cnt + 1;
                last_valid_cyc <= cyc;
                if (valid_cnt > 0) spacing <= cyc - last_valid_cyc;
            end
            if (err === 1'b1) err_cnt <= err_cnt + 1;
            if ((valid === 1'b1 && err === 1'b1) ||
                (valid !== 1'b1 && (m_out !== prev_m || n_out !== prev_n)))
                viol <= viol + 1;
        end
        prev_m <= m_out;
        prev_n <= n_out;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lvl, input int cycles);
        wave_in = lvl;
        tick(cycles);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int vb;
    int eb;

    initial begin
        // Reset state
        reset = 1'b1;
        wave_in = 1'b0;
        tick(5);
        check("rst_m", 32'(m_out), 0);
        check("rst_n", 32'(n_out), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_stuck", 32'(stuck), 0);
        check("rst_state", 32'(o_dbg_state), 32'(IDLE));
        reset = 1'b0;
        tick(3);

        // m=3, n=2: seven rises -> six periods
        vb = valid_cnt; eb = err_cnt;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 30);
            drive(1'b0, 20);
        end
        drive(1'b1, 4);
        check("a_valid_cnt", 32'(valid_cnt - vb), 6);
        check("a_m", 32'(m_out), 3);
        check("a_n", 32'(n_out), 2);
        check("a_spacing", 32'(spacing), 50);
        check("a_err_cnt", 32'(err_cnt - eb), 0);

        // m=1, n=1 (current high completes to 10 cycles)
        vb = valid_cnt;
        drive(1'b1, 6);
        drive(1'b0, 10);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 10);
            drive(1'b0, 10);
        end
        drive(1'b1, 4);
        check("b_valid_cnt", 32'(valid_cnt - vb), 6);
        check("b_m", 32'(m_out), 1);
        check("b_n", 32'(n_out), 1);
        check("b_spacing", 32'(spacing), 20);

        // m=15, n=15: low of exactly 150 cycles is legal
        vb = valid_cnt;
        drive(1'b1, 146);
        drive(1'b0, 150);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 150);
            drive(1'b0, 150);
        end
        drive(1'b1, 4);
        check("c_valid_cnt", 32'(valid_cnt - vb), 3);
        check("c_m", 32'(m_out), 15);
        check("c_n", 32'(n_out), 15);
        check("c_spacing", 32'(spacing), 300);
        check("c_stuck", 32'(stuck), 0);
        check("c_err_cnt", 32'(err_cnt - eb), 0);

        // Malformed period: high 25, low 30
        vb = valid_cnt; eb = err_cnt;
        drive(1'b1, 21);
        drive(1'b0, 30);
        drive(1'b1, 4);
        check("d_err_cnt", 32'(err_cnt - eb), 1);
        check("d_valid_cnt", 32'(valid_cnt - vb), 0);
        check("d_m_hold", 32'(m_out), 15);
        check("d_n_hold", 32'(n_out), 15);

        // Constant low: stuck 151 cycles after the fall is seen
        vb = valid_cnt; eb = err_cnt;
        drive(1'b1, 6);
        drive(1'b0, 152);
        check("e_stuck_before", 32'(stuck), 0);
        tick(1);
        check("e_stuck_at", 32'(stuck), 1);
        check("e_state_stall", 32'(o_dbg_state), 32'(STALL));
        tick(47);
        check("e_err_once", 32'(err_cnt - eb), 1);
        check("e_stuck_hold", 32'(stuck), 1);
        drive(1'b1, 4);
        check("e_stuck_clear", 32'(stuck), 0);
        check("e_state_high", 32'(o_dbg_state), 32'(HIGH));
        drive(1'b1, 16);
        drive(1'b0, 150);
        drive(1'b1, 4);
        check("e_valid_cnt", 32'(valid_cnt - vb), 1);
        check("e_m", 32'(m_out), 2);
        check("e_n", 32'(n_out), 15);
        check("e_stuck_after", 32'(stuck), 0);

        // Low of 151 cycles times out just before the rise is seen
        vb = valid_cnt; eb = err_cnt;
        drive(1'b1, 6);
        drive(1'b0, 151);
        drive(1'b1, 2);
        check("f_stuck", 32'(stuck), 1);
        tick(2);
        check("f_stuck_clear", 32'(stuck), 0);
        check("f_err_cnt", 32'(err_cnt - eb), 1);
        check("f_valid_cnt", 32'(valid_cnt - vb), 0);

        // Reset mid-HIGH, then two rises needed before the next valid
        drive(1'b1, 6);
        drive(1'b0, 10);
        drive(1'b1, 5);
        check("g_pre_m", 32'(m_out), 1);
        check("g_pre_state", 32'(o_dbg_state), 32'(HIGH));
        reset = 1'b1;
        tick(1);
        check("g_rst_m", 32'(m_out), 0);
        check("g_rst_n", 32'(n_out), 0);
        check("g_rst_valid", 32'(valid), 0);
        check("g_rst_err", 32'(err), 0);
        check("g_rst_stuck", 32'(stuck), 0);
        check("g_rst_state", 32'(o_dbg_state), 32'(IDLE));
        reset = 1'b0;
        vb = valid_cnt; eb = err_cnt;
        drive(1'b1, 5);
        check("g_idle_hold", 32'(o_dbg_state), 32'(IDLE));
        drive(1'b0, 20);
        drive(1'b1, 4);
        check("g_first_rise_state", 32'(o_dbg_state), 32'(HIGH));
        check("g_first_rise_valid", 32'(valid_cnt - vb), 0);
        drive(1'b1, 16);
        drive(1'b0, 20);
        drive(1'b1, 4);
        check("g_valid_cnt", 32'(valid_cnt - vb), 1);
        check("g_m", 32'(m_out), 2);
        check("g_n", 32'(n_out), 2);
        check("g_err_cnt", 32'(err_cnt - eb), 0);

        check("protocol_violations", 32'(viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/square_wave_meter.md
# square_wave_meter

Measures an incoming square wave and recovers its on/off intervals in units of `TICK` clock cycles, i.e. the (m, n) pair that produced it. It is the receive-side counterpart of our programmable square-wave generator and sits at the input of a board loopback or an external-signal check path. It reports a new (m, n) pair once per complete period and flags malformed or stalled waveforms.

## Interface
- `TICK`, default 10: clock cycles per interval unit.
- `MAX_UNITS`, default 15: largest legal m or n.
- `clk` in, 1 bit: system clock; all logic on the rising edge.
- `reset` in, 1 bit: synchronous, active-high reset; clock `clk`.
- `wave_in` in, 1 bit: measured waveform, asynchronous to `clk`.
- `m_out` out, 4 bits: last valid high interval in units.
- `n_out` out, 4 bits: last valid low interval in units.
- `valid` out, 1 bit: one-cycle pulse when `m_out`/`n_out` update.
- `err` out, 1 bit: one-cycle pulse when a period is rejected.
- `stuck` out, 1 bit: level; `wave_in` has held one level longer than `MAX_UNITS*TICK` cycles.

## Operation
- Front end: 2-flop synchronizer on `wave_in` to `s2`, plus delayed copy `s3`.
  - `rise` = `s2 & ~s3`; `fall` = `~s2 & s3`.
- FSM states: `IDLE`, `HIGH`, `LOW`, `STALL`.
  - `IDLE`: waits for `rise`, then goes to `HIGH`. Any partial period present at reset is discarded.
  - `HIGH`: counts cycles with `s2`=1 (H). On `fall`, latches H internally and goes to `LOW`.
  - `LOW`: counts cycles with `s2`=0 (L). On `rise`, evaluates the period, then goes to `HIGH` with the count restarted, giving continuous measurement.
- Period evaluation: the period is accepted when both conditions hold:
  - H and L are exact multiples of `TICK`.
  - 1 ≤ H/`TICK` ≤ `MAX_UNITS` and 1 ≤ L/`TICK` ≤ `MAX_UNITS`.
- Accepted period: `m_out`=H/`TICK`, `n_out`=L/`TICK`, pulse `valid`.
- Rejected period: `m_out`/`n_out` hold, pulse `err`.
- Division: no divider. Use a sub-counter 0..`TICK`-1 plus a unit counter.
  - Exact multiple ⇔ sub-counter = 0 at the edge.
  - Unit counter width: 5 bits, so overflow is detectable.
- Timeout: in `HIGH` or `LOW`, a level lasting `MAX_UNITS*TICK`+1 cycles without an edge causes:
  - go to `STALL`, assert `stuck`, pulse `err` once.
  - In `STALL`, the next `rise` clears `stuck` and enters `HIGH`.
  - This covers a generator with m=0 (constant low) or n=0 (constant high).
- Edge versus timeout: an edge arriving when the count equals exactly `MAX_UNITS*TICK` is a legal period end. Timeout cannot coincide with an edge.
- Reset: any cycle, including mid-period. Returns to `IDLE`, all outputs to 0, all counters to 0.

## Timing
- Reset values: `m_out`=0, `n_out`=0, `valid`=0, `err`=0, `stuck`=0.
- Input latency: a `wave_in` transition first sampled at edge k is seen as `rise`/`fall` in the cycle after edge k+1.
- `valid`/`err` are registered at edge k+2 and high for exactly one cycle.
- Steady state: one `valid` per period, spaced (m+n)·`TICK` cycles apart.
- The first `valid` follows the second observed rising edge after reset or after `STALL`.
- `valid` and `err` are never high in the same cycle.
- `m_out` and `n_out` change only in the cycle `valid` is high.
- All outputs are registered, with no combinational path from `wave_in`.

## Structure
- Package `sqw_pkg`:
  - state enum `sqw_meter_state_t` {`IDLE`, `HIGH`, `LOW`, `STALL`}
  - `SQW_TICK_DEFAULT`=10, `SQW_MAX_UNITS`=15
  - `sqw_units_t` = `logic [3:0]`, shared with the generator's m/n ports.
- Sub-module `sqw_sync_edge`: synchronizer, `s3` delay, `rise`/`fall` outputs. It is reusable by other async-input blocks.
- Top level: FSM, sub/unit counters, H latch, output registers.

## Test plan
- Generator m=3, n=2 drives `wave_in` → after the second rise, `valid` every 50 cycles with `m_out`=3, `n_out`=2; `err` never asserted.
- Boundaries m=1,n=1 then m=15,n=15 → (1,1) every 20 cycles, then (15,15) every 300 cycles. The first period after the switch may pulse `err` or report the mixed pair; stable afterwards.
- Hand-driven high 25 cycles, low 30 cycles → `err` pulse; `m_out`/`n_out` keep their previous values.
- Constant low for 200 cycles after a fall → `stuck` rises 151 cycles after the fall is seen, with one `err` pulse. The next rise clears `stuck`, and a further full period gives `valid`.
- Low of exactly 150 cycles → accepted with `n_out`=15, no `stuck`. Low of 151 cycles → `stuck`.
- `reset` asserted mid-`HIGH` for 1 cycle → next cycle all outputs are 0 and state is `IDLE`. The next `valid` comes only after two subsequent rising edges.
